// File: rtl/and_gate.sv
// Registered bitwise AND of two WIDTH-bit vectors with reduction flags and popcount.
// Latency PIPE_STAGES cycles; one result per cycle; no backpressure, no stalls.
module and_gate #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic [WIDTH-1:0]           F,
  output logic                       F_ALL,
  output logic                       F_ANY,
  output logic [$clog2(WIDTH+1)-1:0] F_ONES,
  output logic                       out_valid
);
  localparam int OW = $clog2(WIDTH+1);

  logic [WIDTH-1:0]       r_dat [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_vld;
  logic                   r_all;
  logic                   r_any;
  logic [OW-1:0]          r_ones;

  logic [WIDTH-1:0]       w_and;
  logic [WIDTH-1:0]       w_src;
  logic                   w_flag_en;

  function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [OW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + OW'(v[i]);
    end
    return cnt;
  endfunction

  assign w_and = A & B;

  // Flags are computed one stage early so they land in the same cycle as F.
  // With a single stage they must follow the hold-on-gap rule of stage 1.
  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign w_src     = w_and;
      assign w_flag_en = in_valid;
    end else begin : g_multi
      assign w_src     = r_dat[PIPE_STAGES-2];
      assign w_flag_en = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_dat[i] <= '0;
      end
      r_vld  <= '0;
      r_all  <= 1'b0;
      r_any  <= 1'b0;
      r_ones <= '0;
    end else begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_dat[0] <= w_and;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_dat[i] <= r_dat[i-1];
        r_vld[i] <= r_vld[i-1];
      end
      if (w_flag_en) begin
        r_all  <= &w_src;
        r_any  <= |w_src;
        r_ones <= popcount(w_src);
      end
    end
  end

  assign F         = r_dat[PIPE_STAGES-1];
  assign F_ALL     = r_all;
  assign F_ANY     = r_any;
  assign F_ONES    = r_ones;
  assign out_valid = r_vld[PIPE_STAGES-1];
endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: several WIDTH/PIPE_STAGES instances share one stimulus stream,
// checked every cycle by a delayed-reference scoreboard plus directed vector tables.
module tb_and_gate;
  localparam int NI = 9;
  localparam int CW [NI] = '{1, 8, 8, 64, 7, 32, 1, 7, 32};
  localparam int CP [NI] = '{1, 3, 2, 1,  1, 1,  4, 4, 4};

  typedef logic [73:0] out_t;  // {ov, all, any, ones[6:0], f[63:0]}
  typedef struct packed {
    logic        vld;
    logic [63:0] f;
  } exp_t;
  typedef struct {
    int          inst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ef;
    int          eones;
    logic        eall;
    logic        eany;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;

  logic [63:0] o_f    [NI];
  logic [6:0]  o_ones [NI];
  logic        o_all  [NI];
  logic        o_any  [NI];
  logic        o_ov   [NI];

  logic [63:0] held [NI];
  exp_t        sbq  [NI][$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = CW[g];
    localparam int P = CP[g];
    logic [W-1:0]             f;
    logic [$clog2(W+1)-1:0]   ones;
    logic                     all_f;
    logic                     any_f;
    logic                     ov;
    and_gate #(.WIDTH(W), .PIPE_STAGES(P)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .A        (A[W-1:0]),
      .B        (B[W-1:0]),
      .F        (f),
      .F_ALL    (all_f),
      .F_ANY    (any_f),
      .F_ONES   (ones),
      .out_valid(ov)
    );
    assign o_f[g]    = 64'(f);
    assign o_ones[g] = 7'(ones);
    assign o_all[g]  = all_f;
    assign o_any[g]  = any_f;
    assign o_ov[g]   = ov;
  end

  function automatic logic [63:0] mask(input int w);
    logic [63:0] m;
    m = 64'hFFFF_FFFF_FFFF_FFFF;
    return m >> (64 - w);
  endfunction

  function automatic out_t mk(input logic v, input logic al, input logic an,
                              input int ones, input logic [63:0] f);
    return {v, al, an, 7'(ones), f};
  endfunction

  function automatic out_t exp_out(input int w, input logic v, input logic [63:0] f);
    int ones;
    ones = $countones(f);
    return {v, (ones == w), (ones != 0), 7'(ones), f};
  endfunction

  function automatic out_t dut_out(input int g);
    return {o_ov[g], o_all[g], o_any[g], o_ones[g], o_f[g]};
  endfunction

  task automatic chk(input string nm, input out_t act, input out_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got ov=%b all=%b any=%b ones=%0d f=%h ; want ov=%b all=%b any=%b ones=%0d f=%h",
               nm, act[73], act[72], act[71], act[70:64], act[63:0],
               req[73], req[72], req[71], req[70:64], req[63:0]);
    end
  endtask

  // Expected stage-1 contents are pushed as stimulus is driven; a reset refills
  // the whole pipeline with zeros.
  task automatic sb_push();
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        held[g] = '0;
        sbq[g].delete();
        for (int k = 0; k < CP[g]; k++) sbq[g].push_back({1'b0, 64'h0});
      end else if (in_valid) begin
        held[g] = A & B & mask(CW[g]);
        sbq[g].push_back({1'b1, held[g]});
      end else begin
        sbq[g].push_back({1'b0, held[g]});
      end
    end
  endtask

  task automatic sb_check();
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (sbq[g].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb[%0d]: scoreboard queue empty", g);
      end else begin
        e = sbq[g].pop_front();
        chk($sformatf("sb[%0d] W%0d P%0d", g, CW[g], CP[g]), dut_out(g),
            exp_out(CW[g], e.vld, e.f));
      end
    end
  endtask

  task automatic tick();
    sb_push();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  initial begin
    vec_t        vt [8];
    out_t        exp3 [6];
    out_t        exp4 [5];
    logic [63:0] a3 [3];
    logic [63:0] b3 [3];
    logic        v4 [5];
    int          sel;

    vt[0] = '{0, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0};
    vt[1] = '{0, 64'h0, 64'h1, 64'h0, 0, 1'b0, 1'b0};
    vt[2] = '{0, 64'h1, 64'h0, 64'h0, 0, 1'b0, 1'b0};
    vt[3] = '{0, 64'h1, 64'h1, 64'h1, 1, 1'b1, 1'b1};
    vt[4] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
              64'h8000_0000_0000_0001, 2, 1'b0, 1'b1};
    vt[5] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b1};
    vt[6] = '{4, 64'h7F, 64'h7F, 64'h7F, 7, 1'b1, 1'b1};
    vt[7] = '{4, 64'h7F, 64'h55, 64'h55, 4, 1'b0, 1'b1};

    a3 = '{64'hF0, 64'hFF, 64'hAA};
    b3 = '{64'h3C, 64'hFF, 64'h55};
    exp3 = '{mk(0, 0, 0, 0, 64'h0), mk(0, 0, 0, 0, 64'h0), mk(1, 0, 1, 2, 64'h30),
             mk(1, 1, 1, 8, 64'hFF), mk(1, 0, 0, 0, 64'h0), mk(0, 0, 0, 0, 64'h0)};
    v4   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp4 = '{mk(0, 0, 0, 0, 64'h0), mk(1, 0, 1, 4, 64'h0F), mk(0, 0, 1, 4, 64'h0F),
             mk(0, 0, 1, 4, 64'h0F), mk(1, 0, 1, 4, 64'h0F)};

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (2) tick();
    chk("reset_w1", dut_out(0), '0);
    chk("reset_w64", dut_out(3), '0);

    // Truth table and wide/odd-width vectors on single-stage instances.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      A = vt[i].a;
      B = vt[i].b;
      tick();
      chk($sformatf("vec%0d", i), dut_out(vt[i].inst),
          mk(1'b1, vt[i].eall, vt[i].eany, vt[i].eones, vt[i].ef));
    end

    // Reset dominates in_valid, then release, then reset mid-stream.
    rst = 1'b1;
    in_valid = 1'b1;
    A = '1;
    B = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_hold%0d_w1", i), dut_out(0), '0);
      chk($sformatf("rst_hold%0d_w8p3", i), dut_out(1), '0);
    end
    rst = 1'b0;
    tick();
    chk("rst_release", dut_out(0), mk(1, 1, 1, 1, 64'h1));
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_w1", dut_out(0), '0);
    chk("rst_mid_w8p3", dut_out(1), '0);

    rst = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();

    // Back-to-back through three stages.
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin
        A = a3[i];
        B = b3[i];
      end
      tick();
      chk($sformatf("b2b_p3_%0d", i), dut_out(1), exp3[i]);
    end

    // Valid gaps through two stages; F holds the last captured value.
    A = 64'h0F;
    B = 64'h0F;
    for (int i = 0; i < 5; i++) begin
      in_valid = v4[i];
      tick();
      chk($sformatf("gap_p2_%0d", i), dut_out(2), exp4[i]);
    end

    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 3);
      A = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      B = (sel == 1) ? A : {$urandom, $urandom};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Clocked, parameterizable bitwise AND unit.
- Computes F = A & B over WIDTH-bit operands through a PIPE_STAGES-deep register pipeline.
- Also produces reduction flags and a population count of the result.
- Used as a leaf logic primitive wherever a registered, valid-qualified AND of two vectors is needed; with WIDTH=1 it behaves as a registered 2-input AND gate.

Parameters:
- WIDTH, 1, operand/result width in bits; legal range 1..64.
- PIPE_STAGES, 1, input-to-output latency in clock cycles; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A/B for capture this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- F  output  WIDTH  registered A & B.
- F_ALL  output  1  1 when every bit of F is 1 (reduction AND of F).
- F_ANY  output  1  1 when at least one bit of F is 1 (reduction OR of F).
- F_ONES  output  $clog2(WIDTH+1)  count of 1 bits in F.
- out_valid  output  1  F and the flags correspond to a captured input.

Behaviour:
- Reset
  - Sampled only on a clk rising edge while rst=1; no asynchronous path.
  - Clears every pipeline stage: F=0, F_ALL=0, F_ANY=0, F_ONES=0, out_valid=0.
  - F_ALL is forced to 0 in reset even though F=0 (explicit reset value, not derived).
  - rst has priority over in_valid in the same cycle.
  - Reset mid-operation discards all in-flight data; the first post-reset capture is the first cycle with rst=0 and in_valid=1.
- Datapath
  - Stage 1 computes A & B bitwise, zero-extended to nothing (same width).
  - Each later stage copies the previous one.
  - F, F_ALL, F_ANY and F_ONES are all driven from registers of the final stage; no combinational path from A/B to any output.
  - Reduction flags and popcount are computed from the stage-(PIPE_STAGES-1) value (or from A & B when PIPE_STAGES=1) and registered alongside F, so all outputs are mutually consistent in every cycle.
- Latency and valid
  - Input captured on edge N (in_valid=1) appears on the outputs after edge N+PIPE_STAGES-1, i.e. visible in the cycle following edge N+PIPE_STAGES-1.
  - PIPE_STAGES=1 gives one-cycle latency.
  - A valid bit travels with the data through every stage; out_valid = valid bit of the final stage.
- Gaps
  - When in_valid=0, stage 1 data holds its previous value and its valid bit loads 0.
  - Downstream stages always shift, so F may hold stale data while out_valid=0.
  - Consumers must qualify all outputs with out_valid.
- Throughput
  - One result per cycle; no backpressure, no stalls.
  - Back-to-back valid inputs produce back-to-back valid outputs in order.
- Arithmetic
  - F_ONES ranges 0..WIDTH.
  - F_ALL=1 iff F_ONES==WIDTH.
  - F_ANY=1 iff F_ONES!=0.
  - WIDTH=1: F_ALL=F_ANY=F, and F_ONES is 1 bit equal to F.
- Unknowns: X/Z on A/B with in_valid=1 propagates; no sanitizing.

Test Plan:
1. WIDTH=1, PIPE_STAGES=1, in_valid=1: apply (A,B)=(0,0),(0,1),(1,0),(1,1) on successive cycles -> one cycle later F=0,0,0,1, F_ALL=F_ANY=F_ONES=F, out_valid=1 throughout.
2. Reset: hold rst=1 with in_valid=1, A=B=1 for 3 cycles -> all outputs 0. Deassert rst -> F=1, out_valid=1 one cycle later. Assert rst again mid-stream -> outputs 0 on the next edge.
3. WIDTH=8, PIPE_STAGES=3: A=8'hF0,B=8'h3C then A=8'hFF,B=8'hFF then A=8'hAA,B=8'h55 back-to-back -> three cycles later F=8'h30 (ONES=2, ANY=1, ALL=0), then 8'hFF (ONES=8, ALL=1), then 8'h00 (ONES=0, ANY=0), out_valid high for 3 consecutive cycles.
4. Valid gaps, WIDTH=8, PIPE_STAGES=2: in_valid pattern 1,0,0,1 with A=B=8'h0F on valid cycles -> out_valid pattern 1,0,0,1 delayed by 2; F=8'h0F when valid.
5. WIDTH=64: A=all ones, B=64'h8000_0000_0000_0001 -> F=B, F_ONES=2, F_ANY=1, F_ALL=0; A=B=all ones -> F_ONES=64, F_ALL=1.
6. Random regression: 10k random A/B/in_valid for each WIDTH in {1,7,32} and PIPE_STAGES in {1,4}, with random rst pulses -> outputs match a delayed reference model cycle-exactly.
